// File: rtl/cdb_arbiter.sv
// Two-bus result broadcast arbiter: per-requester FIFOs, round-robin dual grant, registered CDB outputs.
// Optional build macro CDB_STATS_EN adds stat_grants / stat_stalls counters.
module cdb_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 2,
    parameter int TAGW  = 5,
    parameter int DATAW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*TAGW-1:0]  req_tag,
    input  logic [NREQ*DATAW-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  cdb_valid0,
    output logic [TAGW-1:0]       cdb_tag0,
    output logic [DATAW-1:0]      cdb_data0,
    output logic                  cdb_valid1,
    output logic [TAGW-1:0]       cdb_tag1,
    output logic [DATAW-1:0]      cdb_data1
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_stalls
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0][CW-1:0]    cnt;
    logic [NREQ-1:0][TAGW-1:0]  head_tag;
    logic [NREQ-1:0][DATAW-1:0] head_data;
    logic [NREQ-1:0]            pop;
    logic [IW-1:0]              rr_ptr, g0_idx, g1_idx, last_idx, rr_nxt;
    logic                       g0_vld, g1_vld;

    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        logic [TAGW-1:0]  tag_mem  [DEPTH];
        logic [DATAW-1:0] data_mem [DEPTH];
        logic [PW-1:0]    rd_ptr, wr_ptr;
        logic [CW-1:0]    count;
        logic             push;

        assign req_ready[i] = (count < CW'(DEPTH));
        assign push         = req_valid[i] & req_ready[i];
        assign cnt[i]       = count;
        assign head_tag[i]  = tag_mem[rd_ptr];
        assign head_data[i] = data_mem[rd_ptr];

        // Storage is written on any accepted push; a flush resets the pointers so the entry is dead.
        always_ff @(posedge clk) begin
            if (push) begin
                tag_mem[wr_ptr]  <= req_tag[i*TAGW +: TAGW];
                data_mem[wr_ptr] <= req_data[i*DATAW +: DATAW];
            end
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)   wr_ptr <= wr_ptr + 1'b1;
                if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop[i]);
            end
        end
    end

    // Scan from rr_ptr; first two non-empty heads win bus0 then bus1.
    always_comb begin
        logic [IW:0] s;
        s      = '0;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, rr_ptr} + (IW+1)'(k);
            if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
            if (cnt[s[IW-1:0]] != '0) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = s[IW-1:0];
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = s[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (g0_vld) pop[g0_idx] = 1'b1;
        if (g1_vld) pop[g1_idx] = 1'b1;
    end

    assign last_idx = g1_vld ? g1_idx : g0_idx;
    assign rr_nxt   = (last_idx == IW'(NREQ-1)) ? '0 : last_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid0 <= 1'b0;
            cdb_tag0   <= '0;
            cdb_data0  <= '0;
            cdb_valid1 <= 1'b0;
            cdb_tag1   <= '0;
            cdb_data1  <= '0;
        end else begin
            cdb_valid0 <= g0_vld;
            cdb_tag0   <= g0_vld ? head_tag[g0_idx]  : '0;
            cdb_data0  <= g0_vld ? head_data[g0_idx] : '0;
            cdb_valid1 <= g1_vld;
            cdb_tag1   <= g1_vld ? head_tag[g1_idx]  : '0;
            cdb_data1  <= g1_vld ? head_data[g1_idx] : '0;
        end
    end

    // Flush keeps the pointer so fairness carries across a squash.
    always_ff @(posedge clk) begin
        if (rst)                  rr_ptr <= '0;
        else if (!flush && g0_vld) rr_ptr <= rr_nxt;
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            stat_grants <= stat_grants + 32'(cdb_valid0) + 32'(cdb_valid1);
            if ((req_valid & ~req_ready) != '0) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule
